pic_control_logic_param: RTL

- Parametrised successor to the 8259A control-logic block.
- Owns the ICW1..ICW4 initialisation sequencer, OCW2 end-of-interrupt and rotate decode, and the INTA acknowledge sequencer.
- Supports 2, 4 or 8 IRQ channels, MCS-80 (3-pulse) and 8086 (2-pulse) acknowledge, auto-EOI, and master/slave cascade with a configurable cascade width.
- Sits between the bus/read-write decoder and the IRR/ISR/priority-resolver blocks. Fully synchronous to one clock, replacing the combinational INTA handling of the previous generation.

---
 rtl/pic_pkg.sv | 29 ++
 rtl/pic_ack_sequencer.sv | 162 ++++++++++++++++
 rtl/pic_control_logic_param.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared types, opcodes and index helpers for the parametrised interrupt-controller control logic.
package pic_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} init_state_e;
  typedef enum logic [1:0] {A_IDLE, A_1, A_2, A_3} ack_state_e;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;
  localparam logic [2:0] OCW2_SET_PRI    = 3'b110;

  // Both helpers work on the widest (8-channel) form; callers size-cast to their width.
  function automatic logic [2:0] onehot2idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] idx2onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/pic_ack_sequencer.sv
// INTA edge detection, acknowledge FSM and vector-byte formatting.
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               abort_i,
  input  logic               init_done_i,
  input  logic               inta_n_i,
  input  logic [NUM_IRQ-1:0] interrupt_i,
  input  logic               ltim_i,
  input  logic               adi_i,
  input  logic               upm_i,
  input  logic               aeoi_i,
  input  logic [2:0]         a7_5_i,
  input  logic [7:0]         icw2_i,
  input  logic               cd_en_i,
  input  logic               vec_en_i,
  output logic               interrupt_to_cpu_o,
  output logic               freeze_o,
  output logic               latch_in_service_o,
  output logic [NUM_IRQ-1:0] clear_interrupt_request_o,
  output logic [NUM_IRQ-1:0] eoi_o,
  output logic [IDX_W-1:0]   ack_idx_o,
  output logic               oe_o,
  output logic [7:0]         data_o
);

  ack_state_e         state_q, state_d;
  logic               inta_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_IRQ-1:0] onehot_q, onehot_d;
  logic               int_hold_q, int_hold_d;
  logic               latch_q, latch_d;
  logic [NUM_IRQ-1:0] clr_q, clr_d, eoi_q, eoi_d;
  logic               oe_q, oe_d;
  logic [7:0]         data_q, data_d;
  logic               fall, rise, start, final_edge;
  logic [2:0]         idx3;
  logic [7:0]         vec80, vec86;

  assign fall  = inta_q & ~inta_n_i;
  assign rise  = ~inta_q & inta_n_i;
  assign idx3  = 3'(idx_q);
  assign vec80 = adi_i ? {a7_5_i, idx3, 2'b00} : {a7_5_i[2:1], idx3, 3'b000};
  assign vec86 = {icw2_i[7:IDX_W], idx_q};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    onehot_d   = onehot_q;
    int_hold_d = int_hold_q;
    latch_d    = 1'b0;
    clr_d      = '0;
    eoi_d      = '0;
    oe_d       = 1'b0;
    data_d     = '0;
    start      = 1'b0;
    final_edge = 1'b0;

    case (state_q)
      A_IDLE: if (fall && init_done_i) begin
        state_d = A_1;
        start   = 1'b1;
      end
      A_1: if (fall) state_d = A_2;
      A_2: begin
        if (upm_i) begin
          if (rise) begin
            state_d    = A_IDLE;
            final_edge = 1'b1;
          end
        end else if (fall) begin
          state_d = A_3;
        end
      end
      A_3: if (rise) begin
        state_d    = A_IDLE;
        final_edge = 1'b1;
      end
      default: state_d = A_IDLE;
    endcase

    // An empty request at the first pulse is spurious: report the lowest level, latch nothing.
    if (start) begin
      int_hold_d = |interrupt_i;
      onehot_d   = interrupt_i;
      idx_d      = (|interrupt_i) ? IDX_W'(onehot2idx(8'(interrupt_i))) : IDX_W'(NUM_IRQ - 1);
      latch_d    = |interrupt_i;
      clr_d      = ltim_i ? '0 : interrupt_i;
    end

    if (final_edge && aeoi_i) eoi_d = onehot_q;

    if (!inta_n_i) begin
      case (state_d)
        A_1: if (!upm_i && cd_en_i) begin
          oe_d   = 1'b1;
          data_d = CALL_OPCODE;
        end
        A_2: if (vec_en_i) begin
          oe_d   = 1'b1;
          data_d = upm_i ? vec86 : vec80;
        end
        A_3: if (vec_en_i) begin
          oe_d   = 1'b1;
          data_d = icw2_i;
        end
        default: ;
      endcase
    end

    if (abort_i) begin
      state_d    = A_IDLE;
      int_hold_d = 1'b0;
      latch_d    = 1'b0;
      clr_d      = '0;
      eoi_d      = '0;
      oe_d       = 1'b0;
      data_d     = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= A_IDLE;
      inta_q     <= 1'b0;
      idx_q      <= '0;
      onehot_q   <= '0;
      int_hold_q <= 1'b0;
      latch_q    <= 1'b0;
      clr_q      <= '0;
      eoi_q      <= '0;
      oe_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      inta_q     <= inta_n_i;
      idx_q      <= idx_d;
      onehot_q   <= onehot_d;
      int_hold_q <= int_hold_d;
      latch_q    <= latch_d;
      clr_q      <= clr_d;
      eoi_q      <= eoi_d;
      oe_q       <= oe_d;
      data_q     <= data_d;
    end
  end

  assign interrupt_to_cpu_o        = (state_q == A_IDLE) ? (init_done_i & |interrupt_i) : int_hold_q;
  assign freeze_o                  = (state_q != A_IDLE);
  assign latch_in_service_o        = latch_q;
  assign clear_interrupt_request_o = clr_q;
  assign eoi_o                     = eoi_q;
  assign ack_idx_o                 = idx_q;
  assign oe_o                      = oe_q;
  assign data_o                    = data_q;

endmodule

// File: rtl/pic_control_logic_param.sv
// Control logic top: ICW init sequencer, OCW2 EOI/rotate decode and cascade steering.
module pic_control_logic_param
  import pic_pkg::*;
#(
  parameter int NUM_IRQ   = 8,
  parameter int IDX_W     = $clog2(NUM_IRQ),
  parameter int CASCADE_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 interrupt_acknowledge_n,
  input  logic [7:0]           internal_data_bus,
  input  logic                 write_initial_command_word_1,
  input  logic                 write_initial_command_word_2_4,
  input  logic                 write_operation_control_word_2,
  input  logic                 slave_program_n,
  input  logic [CASCADE_W-1:0] cascade_in,
  input  logic [NUM_IRQ-1:0]   interrupt,
  input  logic [NUM_IRQ-1:0]   highest_level_in_service,
  output logic                 interrupt_to_cpu,
  output logic                 freeze,
  output logic                 latch_in_service,
  output logic [NUM_IRQ-1:0]   clear_interrupt_request,
  output logic [NUM_IRQ-1:0]   end_of_interrupt,
  output logic [IDX_W-1:0]     priority_rotate,
  output logic                 level_or_edge_triggered_config,
  output logic                 special_fully_nest_config,
  output logic [CASCADE_W-1:0] cascade_out,
  output logic                 out_control_logic_data,
  output logic [7:0]           control_logic_data,
  output logic                 init_done
);

  init_state_e        init_q, init_d;
  logic               ltim_q, ltim_d, adi_q, adi_d, sngl_q, sngl_d, ic4_q, ic4_d;
  logic               upm_q, upm_d, aeoi_q, aeoi_d, sfnm_q, sfnm_d;
  logic [2:0]         a7_5_q, a7_5_d;
  logic [7:0]         icw2_q, icw2_d, icw3_q, icw3_d;
  logic [IDX_W-1:0]   rot_q, rot_d;
  logic [NUM_IRQ-1:0] ocw_eoi_q, ocw_eoi_d;

  logic [IDX_W-1:0]   l_idx, hlis_idx, ack_idx;
  logic [NUM_IRQ-1:0] l_onehot, seq_eoi;
  logic               slave, cascaded_master, cd_en, vec_en;

  assign l_idx    = internal_data_bus[IDX_W-1:0];
  assign l_onehot = NUM_IRQ'(idx2onehot(3'(l_idx)));
  assign hlis_idx = IDX_W'(onehot2idx(8'(highest_level_in_service)));

  always_comb begin
    init_d    = init_q;
    ltim_d    = ltim_q;
    adi_d     = adi_q;
    sngl_d    = sngl_q;
    ic4_d     = ic4_q;
    upm_d     = upm_q;
    aeoi_d    = aeoi_q;
    sfnm_d    = sfnm_q;
    a7_5_d    = a7_5_q;
    icw2_d    = icw2_q;
    icw3_d    = icw3_q;
    rot_d     = rot_q;
    ocw_eoi_d = '0;

    if (write_initial_command_word_1) begin
      init_d = WAIT_ICW2;
      ltim_d = internal_data_bus[3];
      adi_d  = internal_data_bus[2];
      sngl_d = internal_data_bus[1];
      ic4_d  = internal_data_bus[0];
      a7_5_d = internal_data_bus[7:5];
      upm_d  = 1'b0;
      aeoi_d = 1'b0;
      sfnm_d = 1'b0;
      rot_d  = IDX_W'(NUM_IRQ - 1);
    end else if (write_initial_command_word_2_4) begin
      case (init_q)
        WAIT_ICW2: begin
          icw2_d = internal_data_bus;
          init_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
        end
        WAIT_ICW3: begin
          icw3_d = internal_data_bus;
          init_d = ic4_q ? WAIT_ICW4 : READY;
        end
        WAIT_ICW4: begin
          upm_d  = internal_data_bus[0];
          aeoi_d = internal_data_bus[1];
          sfnm_d = internal_data_bus[4];
          init_d = READY;
        end
        default: ;
      endcase
    end else if (write_operation_control_word_2 && init_q == READY) begin
      case (internal_data_bus[7:5])
        OCW2_NS_EOI: ocw_eoi_d = highest_level_in_service;
        OCW2_SP_EOI: ocw_eoi_d = l_onehot;
        OCW2_ROT_NS_EOI: begin
          ocw_eoi_d = highest_level_in_service;
          if (|highest_level_in_service) rot_d = hlis_idx;
        end
        OCW2_ROT_SP_EOI: begin
          ocw_eoi_d = l_onehot;
          rot_d     = l_idx;
        end
        OCW2_SET_PRI: rot_d = l_idx;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_q    <= IDLE;
      ltim_q    <= 1'b0;
      adi_q     <= 1'b0;
      sngl_q    <= 1'b0;
      ic4_q     <= 1'b0;
      upm_q     <= 1'b0;
      aeoi_q    <= 1'b0;
      sfnm_q    <= 1'b0;
      a7_5_q    <= '0;
      icw2_q    <= '0;
      icw3_q    <= '0;
      rot_q     <= IDX_W'(NUM_IRQ - 1);
      ocw_eoi_q <= '0;
    end else begin
      init_q    <= init_d;
      ltim_q    <= ltim_d;
      adi_q     <= adi_d;
      sngl_q    <= sngl_d;
      ic4_q     <= ic4_d;
      upm_q     <= upm_d;
      aeoi_q    <= aeoi_d;
      sfnm_q    <= sfnm_d;
      a7_5_q    <= a7_5_d;
      icw2_q    <= icw2_d;
      icw3_q    <= icw3_d;
      rot_q     <= rot_d;
      ocw_eoi_q <= ocw_eoi_d;
    end
  end

  // A master whose acknowledged level has a slave hands the vector bytes to that slave.
  assign slave           = ~slave_program_n;
  assign cascaded_master = ~sngl_q & slave_program_n & icw3_q[ack_idx];
  assign cd_en           = ~slave;
  assign vec_en          = slave ? (cascade_in == icw3_q[CASCADE_W-1:0]) : ~cascaded_master;

  pic_ack_sequencer #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_ack (
    .clock                     (clock),
    .reset                     (reset),
    .abort_i                   (write_initial_command_word_1),
    .init_done_i               (init_done),
    .inta_n_i                  (interrupt_acknowledge_n),
    .interrupt_i               (interrupt),
    .ltim_i                    (ltim_q),
    .adi_i                     (adi_q),
    .upm_i                     (upm_q),
    .aeoi_i                    (aeoi_q),
    .a7_5_i                    (a7_5_q),
    .icw2_i                    (icw2_q),
    .cd_en_i                   (cd_en),
    .vec_en_i                  (vec_en),
    .interrupt_to_cpu_o        (interrupt_to_cpu),
    .freeze_o                  (freeze),
    .latch_in_service_o        (latch_in_service),
    .clear_interrupt_request_o (clear_interrupt_request),
    .eoi_o                     (seq_eoi),
    .ack_idx_o                 (ack_idx),
    .oe_o                      (out_control_logic_data),
    .data_o                    (control_logic_data)
  );

  assign init_done                      = (init_q == READY);
  assign end_of_interrupt               = ocw_eoi_q | seq_eoi;
  assign priority_rotate                = rot_q;
  assign level_or_edge_triggered_config = ltim_q;
  assign special_fully_nest_config      = sfnm_q;
  assign cascade_out                    = (freeze && cascaded_master) ? CASCADE_W'(ack_idx) : '0;

endmodule
